serial_mux_addsub: RTL and testbench
====================================

Name: serial_mux_addsub

Overview:
Parametrised multi-cycle adder/subtractor. Each slice is built from mux-based full-adder cells (2:1 muxes only, no behavioural "+").
Processes BPC bits per clock from LSB to MSB and keeps the carry in a register between cycles. The design trades latency for area.
A start/busy/done handshake lets the block sit in datapaths where area matters more than throughput.

Parameters:
WIDTH, 8, operand and result width in bits; must be ≥ 2.
BPC, 1, bits processed per cycle. WIDTH mod BPC must be 0, checked at elaboration. N = WIDTH/BPC compute cycles.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
a  input  WIDTH  operand A, captured on the accepted start
b  input  WIDTH  operand B, captured on the accepted start
cin  input  1  carry-in (add) / borrow-in (sub), captured on start
sub  input  1  0: a+b+cin; 1: a-b-cin; captured on start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when results update
sum  output  WIDTH  registered result
cout  output  1  registered final carry-out (sub: 1 = no borrow)
overflow  output  1  registered signed overflow

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; busy, done, sum, cout, overflow all 0. Internal shift registers, carry and slice counter are cleared.
- States:
  - IDLE → RUN on a clock edge with start=1.
  - RUN stays in RUN for N edges.
  - RUN → IDLE on the edge that processes the last slice.
- Capture on the accepted start edge:
  - A_reg = a.
  - B_reg = sub ? ~b : b.
  - carry = sub XOR cin, so sub computes a + ~b + ~cin = a − b − cin.
  - Slice count = 0. busy = 1.
- Each RUN edge:
  - Feed the BPC LSBs of A_reg/B_reg with the carry into a BPC-long ripple of mux full-adder cells.
  - Shift the BPC sum bits into the top of a result shift register.
  - Shift A_reg/B_reg right by BPC.
  - carry ← ripple carry-out. Count increments.
- Final edge (count = N−1):
  - sum ← completed result; cout ← final carry.
  - overflow ← carry into the MSB XOR carry out of the MSB. The MSB-slice internal carry is kept for this.
  - done = 1 for exactly the following cycle; busy = 0 in that same cycle.
- Latency:
  - start accepted at edge 0 → done high after edge N.
  - Throughput is one operation per N+1 cycles minimum. A new start is accepted in the cycle done is high.
- start while busy: ignored, with no effect on operands or progress.
- Input changes while busy: ignored; operands are captured once.
- sum, cout and overflow hold their last values between done pulses. They are never updated mid-operation.
- BPC = WIDTH: single compute cycle, so done follows 1 edge after start.
- Wrap-around: results are modulo 2^WIDTH; cout carries bit WIDTH.
- Reset mid-operation aborts immediately. No done pulse; all outputs return to 0.
- No X may propagate to outputs from uninitialised shift registers.

Test Plan:
1. WIDTH=8, BPC=1: a=0x5A, b=0x3C, cin=0, sub=0, start 1 cycle → busy high 8 cycles, done pulses after 8th edge. sum=0x96, cout=0, overflow=1.
2. WIDTH=8, BPC=1: a=0xFF, b=0x01, cin=0, sub=0 → sum=0x00, cout=1, overflow=0. Then a=0x7F, b=0x00, cin=1 → sum=0x80, overflow=1.
3. Subtract: a=0x10, b=0x20, cin=0, sub=1 → sum=0xF0, cout=0, overflow=0. Then a=0x80, b=0x01, sub=1 → sum=0x7F, cout=1, overflow=1.
4. Protocol: start re-asserted while busy with a=0x01, b=0x01 → ignored; first result is unchanged. Start asserted in the done cycle is accepted, with done for it exactly N+1 cycles later.
5. Reset mid-op: start a=0xAA, b=0x55, drop rst_n at cycle 4 for 1 cycle → all outputs 0, no done pulse. A fresh start afterwards gives the correct 0xFF.
6. Parameter sweep (BPC=2, 4, 8 with WIDTH=8; WIDTH=16 with BPC=4):
   - done latency is exactly N = 4, 2, 1, 4 respectively.
   - 1000 random operands (random sub/cin) match a reference model for sum, cout and overflow.

Source files
------------

// File: rtl/serial_mux_addsub.sv
// serial_mux_addsub
//   Multi-cycle adder/subtractor. Each cycle, BPC bits (LSB first) run through
//   a ripple of full-adder cells built only from 2:1 muxes. The carry is held
//   in a register between cycles, so one operation takes N = WIDTH/BPC cycles.
//
// Ports
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   start    : operation request, sampled only while busy = 0
//   a, b     : operands, captured on the accepted start
//   cin      : carry-in (add) / borrow-in (sub), captured on start
//   sub      : 0 -> a + b + cin, 1 -> a - b - cin, captured on start
//   busy     : high while an operation is in progress
//   done     : one-cycle pulse when sum/cout/overflow update
//   sum      : registered result (modulo 2^WIDTH)
//   cout     : registered carry-out (sub: 1 = no borrow)
//   overflow : registered signed overflow
module serial_mux_addsub #(
   parameter int WIDTH = 8,
   parameter int BPC   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int N  = WIDTH / BPC;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   localparam logic IDLE = 1'b0;
   localparam logic RUN  = 1'b1;

   if (WIDTH < 2 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_param_err
      $error("serial_mux_addsub: WIDTH must be >= 2 and a multiple of BPC");
   end

   function automatic logic mux2(input logic sel, input logic d0, input logic d1);
      return sel ? d1 : d0;
   endfunction

   logic             state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic             carry;
   logic [CW-1:0]    cnt;

   // Mux-only ripple over the current slice.
   //   p  = a ^ b      : select between a and ~a on b
   //   s  = p ^ c      : select between c and ~c on p
   //   co = p ? c : a  : when a == b the carry equals a, otherwise it propagates c
   logic [BPC:0]   rc;
   logic [BPC-1:0] rs;
   logic [BPC-1:0] rp;

   always_comb begin
      rc    = '0;
      rs    = '0;
      rp    = '0;
      rc[0] = carry;
      for (int i = 0; i < BPC; i++) begin
         rp[i]   = mux2(b_sh[i], a_sh[i], ~a_sh[i]);
         rs[i]   = mux2(rp[i], rc[i], ~rc[i]);
         rc[i+1] = mux2(rp[i], a_sh[i], rc[i]);
      end
   end

   // Slice sum bits enter at the top; after N slices the result is aligned.
   logic [WIDTH-1:0] res_next;
   if (BPC == WIDTH) begin : g_full
      assign res_next = rs;
   end else begin : g_part
      assign res_next = {rs, res_sh[WIDTH-1:BPC]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         a_sh     <= '0;
         b_sh     <= '0;
         res_sh   <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  // Subtraction is a + ~b + ~cin, so invert b and seed the carry.
                  a_sh  <= a;
                  b_sh  <= sub ? ~b : b;
                  carry <= sub ^ cin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            default: begin
               a_sh   <= a_sh >> BPC;
               b_sh   <= b_sh >> BPC;
               res_sh <= res_next;
               carry  <= rc[BPC];
               cnt    <= cnt + CW'(1);
               if (cnt == LAST) begin
                  // rc[BPC-1] is the carry into bit WIDTH-1 on the final slice.
                  sum      <= res_next;
                  cout     <= rc[BPC];
                  overflow <= rc[BPC] ^ rc[BPC-1];
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_mux_addsub.sv
// Testbench for serial_mux_addsub: five configurations run in parallel
// (WIDTH/BPC = 8/1, 8/2, 8/4, 8/8, 16/4), each with its own driver and
// scoreboard monitor, against an arithmetic reference model.
module tb_serial_mux_addsub;

   logic clk;
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;
   int   ndone = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic. Returns {overflow, cout, sum}.
   function automatic longint model(input int w, input longint ia, input longint ib,
                                    input logic ic, input logic is);
      longint m, h, au, bu, sa, sb, ci, r, sr, s, co, ov;
      m  = longint'(1) << w;
      h  = m / 2;
      au = ia & (m - 1);
      bu = ib & (m - 1);
      ci = ic ? 1 : 0;
      sa = (au >= h) ? au - m : au;
      sb = (bu >= h) ? bu - m : bu;
      if (!is) begin
         r  = au + bu + ci;
         co = (r >= m) ? 1 : 0;
         sr = sa + sb + ci;
      end else begin
         r  = au - bu - ci;
         co = (au >= bu + ci) ? 1 : 0;
         sr = sa - sb - ci;
      end
      s  = r & (m - 1);
      ov = (sr < -h || sr >= h) ? 1 : 0;
      return s | (co << w) | (ov << (w + 1));
   endfunction

   for (genvar g = 0; g < 5; g++) begin : g_cfg
      localparam int W = (g == 4) ? 16 : 8;
      localparam int P = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : (g == 3) ? 8 : 4;
      localparam int N = W / P;
      localparam longint MASK = (longint'(1) << W) - 1;

      logic         rst_n, start, cin, sub, busy, done, cout, overflow;
      logic [W-1:0] a, b, sum;
      longint       expq[$];
      int           latq[$];
      int           busy_run = 0;

      serial_mux_addsub #(.WIDTH(W), .BPC(P)) dut (
         .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
         .sub(sub), .busy(busy), .done(done), .sum(sum), .cout(cout),
         .overflow(overflow)
      );

      // Scoreboard monitor: pops an expectation on every done pulse.
      always @(negedge clk) begin : mon
         longint e;
         int     l;
         if (done) begin
            if (expq.size() == 0) begin
               chk($sformatf("c%0d_spurious_done", g), done, 0);
            end else begin
               e = expq.pop_front();
               l = latq.pop_front();
               chk($sformatf("c%0d_sum", g), longint'(sum), e & MASK);
               chk($sformatf("c%0d_cout", g), cout, (e >> W) & 1);
               chk($sformatf("c%0d_overflow", g), overflow, (e >> (W + 1)) & 1);
               chk($sformatf("c%0d_latency_cycle", g), cyc, l);
               chk($sformatf("c%0d_busy_in_done", g), busy, 0);
               chk($sformatf("c%0d_busy_cycles", g), busy_run, N);
            end
            busy_run = 0;
         end else if (busy) begin
            busy_run++;
         end else begin
            busy_run = 0;
         end
      end

      task automatic wait_idle();
         int k = 0;
         @(negedge clk);
         while (busy && k < 4 * N + 8) begin
            @(negedge clk);
            k++;
         end
         if (busy) chk($sformatf("c%0d_wait_idle", g), busy, 0);
      endtask

      task automatic issue(input longint ia, input longint ib, input logic ic, input logic is);
         wait_idle();
         a     = W'(ia);
         b     = W'(ib);
         cin   = ic;
         sub   = is;
         start = 1'b1;
         expq.push_back(model(W, ia, ib, ic, is));
         latq.push_back(cyc + 1 + N);
         @(posedge clk);
         #1 start = 1'b0;
      endtask

      task automatic drain();
         int k = 0;
         while (expq.size() != 0 && k < 8 * N + 20) begin
            @(negedge clk);
            k++;
         end
         chk($sformatf("c%0d_drain", g), expq.size(), 0);
      endtask

      task automatic chk_zero(input string tag);
         chk($sformatf("c%0d_%s_busy", g, tag), busy, 0);
         chk($sformatf("c%0d_%s_done", g, tag), done, 0);
         chk($sformatf("c%0d_%s_sum", g, tag), longint'(sum), 0);
         chk($sformatf("c%0d_%s_cout", g, tag), cout, 0);
         chk($sformatf("c%0d_%s_overflow", g, tag), overflow, 0);
      endtask

      initial begin : drv
         rst_n = 1'b1;
         start = 1'b0;
         a     = '0;
         b     = '0;
         cin   = 1'b0;
         sub   = 1'b0;
         #2 rst_n = 1'b0;
         #1 chk_zero("reset");
         @(posedge clk);
         #1 rst_n = 1'b1;

         // Directed additions and subtractions, issued back to back.
         issue(64'h5A, 64'h3C, 1'b0, 1'b0);
         issue(64'hFF, 64'h01, 1'b0, 1'b0);
         issue(64'h7F, 64'h00, 1'b1, 1'b0);
         issue(64'h10, 64'h20, 1'b0, 1'b1);
         issue(64'h80, 64'h01, 1'b0, 1'b1);

         // start held while busy with new operands must be ignored.
         issue(64'h33, 64'h44, 1'b1, 1'b0);
         for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            a     = W'(1);
            b     = W'(1);
            cin   = 1'b0;
            sub   = 1'b0;
            start = busy;
         end
         @(posedge clk);
         #1 start = 1'b0;
         drain();

         // Reset in the middle of an operation: immediate abort, no done.
         wait_idle();
         a     = W'(64'hAA);
         b     = W'(64'h55);
         cin   = 1'b0;
         sub   = 1'b0;
         start = 1'b1;
         @(posedge clk);
         #1 start = 1'b0;
         repeat ((N > 3) ? 3 : N - 1) @(posedge clk);
         #1 rst_n = 1'b0;
         #1 chk_zero("midreset");
         @(posedge clk);
         #1 rst_n = 1'b1;
         issue(64'hAA, 64'h55, 1'b0, 1'b0);

         // Random operands, random add/sub and carry.
         for (int i = 0; i < 1000; i++) begin
            issue(longint'($urandom), longint'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end
         drain();
         ndone++;
      end
   end

   initial begin : fin
      int k = 0;
      while (ndone < 5 && k < 60000) begin
         @(posedge clk);
         k++;
      end
      chk("all_configs_finished", ndone, 5);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
